interrupt_scheduler: RTL and testbench
======================================

Name: interrupt_scheduler

Overview:
- Arbitrates the six standard RISC-V interrupt sources (SSI, MSI, STI, MTI, SEI, MEI) against the privilege and enable state.
- Applies a configurable hold-off before raising the request, and latches a stable cause and target mode for the global-control unit.
- Sits between the CSR unit (mip/mie/mideleg/mstatus) and the global-control state machine: drives its interrupt_pending and consumes its interrupt_taken.
- Also generates the WFI wake event.

Parameters:
INCLUDE_S_MODE, 1, when 0 the S-level sources (bits 1/5/9) and mideleg are ignored and S-target is never produced
HOLDOFF_CYCLES, 2, consecutive qualified cycles required before presenting; range 0-15

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
mip  in  12  raw pending bits (only 1,3,5,7,9,11 used)
mie  in  12  per-source enables
mideleg  in  12  delegation to S
privilege  in  2  current mode (0=U, 1=S, 3=M)
mstatus_mie  in  1  M global enable
mstatus_sie  in  1  S global enable
interrupt_taken  in  1  global control has accepted the presented interrupt
wfi_active  in  1  a WFI is stalling the core
interrupt_pending  out  1  request to global control
interrupt_cause  out  4  latched exception code (1,3,5,7,9,11)
interrupt_to_s  out  1  latched target is S-mode
wfi_wake  out  1  wake event for WFI

Behaviour:
- Interface: clock clk; reset rst, synchronous, active-high.
- Qualification (combinational): source i is active if mip[i] & mie[i].
- M-target sources (not delegated, or INCLUDE_S_MODE=0) qualify when privilege<3, or when privilege==3 & mstatus_mie.
- S-target sources (delegated) qualify when privilege==0, or when privilege==1 & mstatus_sie. They never qualify in M.
- Priority, highest first: 11 (MEI), 3 (MSI), 7 (MTI), 9 (SEI), 1 (SSI), 5 (STI). Bits other than 1/3/5/7/9/11 are ignored.
- any_q = OR of all qualified sources; best = highest-priority qualified code.
- States:
  - IDLE: any_q moves to PRESENT if HOLDOFF_CYCLES==0, otherwise to HOLDOFF with cnt=0.
  - HOLDOFF: if ~any_q, go to IDLE. Else if cnt==HOLDOFF_CYCLES-1, go to PRESENT. Else cnt++.
  - PRESENT: interrupt_taken moves to COOLDOWN. Else, if the latched cause is no longer qualified, go to IDLE (withdrawal).
  - COOLDOWN: one cycle, then IDLE unconditionally. Lets CSR updates from trap entry settle.
- Latency: with first qualified cycle = 0 and the source held, interrupt_pending is high from cycle HOLDOFF_CYCLES+1.
- Cause latch: interrupt_cause and interrupt_to_s are captured from best on the transition into PRESENT. They stay constant throughout PRESENT, even if a higher-priority source arrives. Cause changes only on a later re-entry.
- interrupt_pending is registered and high exactly while state==PRESENT.
- Simultaneous taken and withdrawal in PRESENT: taken wins, go to COOLDOWN.
- interrupt_taken outside PRESENT: ignored, no state change.
- Hold-off counter: 4 bits; cleared whenever the state is not HOLDOFF. A qualification drop during HOLDOFF restarts the hold-off from IDLE.
- wfi_wake: registered; equals wfi_active & |(mip & mie) over bits 1/3/5/7/9/11. It ignores global enables, privilege and delegation, per the WFI rule. It is independent of the state machine.
- Reset values: state IDLE, cnt 0, interrupt_pending 0, interrupt_cause 0, interrupt_to_s 0, wfi_wake 0.
- Reset asserted mid-operation (any state) returns to IDLE next edge. Reset overrides a same-cycle interrupt_taken.

Test Plan:
- HOLDOFF_CYCLES=2, privilege=3, mstatus_mie=1, mie[7]=1; raise mip[7] at cycle 0 and hold -> interrupt_pending=1 from cycle 3, cause=7, to_s=0. Taken at cycle 5 -> pending=0 at cycle 6 (COOLDOWN), IDLE at cycle 7, and pending re-asserts at cycle 10 while mip[7] is held.
- mip[5] and mip[11] both enabled, raised together (M mode, mie=1) -> cause=11. Then raise mip[3] while PRESENT -> cause stays 11 until taken.
- mip[7] pulsed for 2 cycles with HOLDOFF_CYCLES=2 -> pending never asserts, state back to IDLE, cnt=0.
- mideleg[9]=1, mip[9]/mie[9]=1: privilege=3 -> no pending. privilege=1, mstatus_sie=1 -> pending with cause=9, to_s=1. Drop mstatus_sie while PRESENT without taken -> withdrawal, pending=0 next cycle. Repeat with INCLUDE_S_MODE=0 -> never pending.
- mstatus_mie=0, privilege=3, mip[11]/mie[11]=1, wfi_active=1 -> wfi_wake=1 next cycle, interrupt_pending stays 0.
- In PRESENT, assert interrupt_taken and rst in the same cycle -> next cycle IDLE, all outputs 0. Separately, assert taken in the same cycle the cause deasserts -> COOLDOWN entered.

Source files
------------

// File: rtl/interrupt_scheduler.sv
// ---------------------------------------------------------------------------
// interrupt_scheduler
//
// Picks the highest-priority RISC-V interrupt source allowed by the current
// privilege, the enables and the delegation state. The source must stay
// qualified for a hold-off period before it is raised to global control.
// While the request is raised, the chosen cause and target mode are held
// stable. The block also produces the WFI wake event.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   mip, mie          raw pending / enable bits (1,3,5,7,9,11 used)
//   mideleg           delegation of a source to S-mode
//   privilege         current mode (0=U, 1=S, 3=M)
//   mstatus_mie/sie   M / S global interrupt enables
//   interrupt_taken   global control accepted the presented interrupt
//   wfi_active        a WFI is stalling the core
//   interrupt_pending request to global control (high while PRESENT)
//   interrupt_cause   latched exception code of the presented interrupt
//   interrupt_to_s    latched target is S-mode
//   wfi_wake          registered wake event for WFI
//   state_dbg         current FSM state (0=IDLE 1=HOLDOFF 2=PRESENT 3=COOLDOWN)
//   holdoff_cnt_dbg   current hold-off counter
//
// Handshake: interrupt_pending acts as "valid" and interrupt_taken acts as
// "ready". A transfer happens on a clock edge where both are high. The
// request then drops for at least one COOLDOWN cycle. interrupt_taken has no
// effect while interrupt_pending is low. The request may also be withdrawn
// without a transfer if its latched cause stops qualifying.
// ---------------------------------------------------------------------------
module interrupt_scheduler #(
    parameter int INCLUDE_S_MODE = 1,
    parameter int HOLDOFF_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] mip,
    input  logic [11:0] mie,
    input  logic [11:0] mideleg,
    input  logic [1:0]  privilege,
    input  logic        mstatus_mie,
    input  logic        mstatus_sie,
    input  logic        interrupt_taken,
    input  logic        wfi_active,
    output logic        interrupt_pending,
    output logic [3:0]  interrupt_cause,
    output logic        interrupt_to_s,
    output logic        wfi_wake,
    output logic [1:0]  state_dbg,
    output logic [3:0]  holdoff_cnt_dbg
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLDOFF  = 2'd1,
        PRESENT  = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    localparam logic [11:0] SRC_MASK  = 12'hAAA;  // bits 1,3,5,7,9,11
    localparam logic [11:0] S_MASK    = 12'h222;  // bits 1,5,9
    localparam logic [11:0] USED_MASK = (INCLUDE_S_MODE != 0) ? SRC_MASK
                                                              : (SRC_MASK & ~S_MASK);
    localparam logic [3:0]  HOLDOFF_LAST = (HOLDOFF_CYCLES == 0) ? 4'd0
                                                                 : 4'(HOLDOFF_CYCLES - 1);

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [11:0] active, deleg, qual;
    logic [15:0] qual16, deleg16;
    logic        m_ok, s_ok, any_q, cause_still_q;
    logic [3:0]  best_code;
    logic        best_to_s;

    // Qualification of each source against its target mode.
    always_comb begin
        active  = mip & mie & USED_MASK;
        deleg   = (INCLUDE_S_MODE != 0) ? mideleg : 12'd0;
        m_ok    = (privilege != 2'd3) || mstatus_mie;
        s_ok    = (privilege == 2'd0) || ((privilege == 2'd1) && mstatus_sie);
        qual    = active & ((deleg & {12{s_ok}}) | (~deleg & {12{m_ok}}));
        any_q   = |qual;
        // The vectors are padded to 16 bits so that any 4-bit code indexes in range.
        qual16  = {4'd0, qual};
        deleg16 = {4'd0, deleg};
        cause_still_q = qual16[interrupt_cause];
    end

    // Fixed priority: MEI, MSI, MTI, SEI, SSI, STI.
    always_comb begin
        best_code = 4'd0;
        if      (qual[11]) best_code = 4'd11;
        else if (qual[3])  best_code = 4'd3;
        else if (qual[7])  best_code = 4'd7;
        else if (qual[9])  best_code = 4'd9;
        else if (qual[1])  best_code = 4'd1;
        else if (qual[5])  best_code = 4'd5;
        best_to_s = deleg16[best_code];
    end

    // State register, hold-off counter, cause latch and wake event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= 4'd0;
            interrupt_cause <= 4'd0;
            interrupt_to_s  <= 1'b0;
            wfi_wake        <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            // Cause and target are frozen for the whole PRESENT stay.
            if ((state != PRESENT) && (state_next == PRESENT)) begin
                interrupt_cause <= best_code;
                interrupt_to_s  <= best_to_s;
            end
            // WFI wakes on any locally enabled pending source. Global enables,
            // privilege and delegation do not affect it.
            wfi_wake <= wfi_active & (|(mip & mie & SRC_MASK));
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        cnt_next   = 4'd0;
        case (state)
            IDLE: begin
                if (any_q) begin
                    state_next = (HOLDOFF_CYCLES == 0) ? PRESENT : HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (!any_q) begin
                    state_next = IDLE;
                end else if (cnt == HOLDOFF_LAST) begin
                    state_next = PRESENT;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            PRESENT: begin
                // If taken and withdrawal happen in the same cycle, taken wins.
                if (interrupt_taken) begin
                    state_next = COOLDOWN;
                end else if (!cause_still_q) begin
                    state_next = IDLE;
                end
            end
            COOLDOWN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        interrupt_pending = (state == PRESENT);
        state_dbg         = state;
        holdoff_cnt_dbg   = cnt;
    end

endmodule

// File: tb/tb_interrupt_scheduler.sv
// ---------------------------------------------------------------------------
// tb_interrupt_scheduler
//
// Bench for interrupt_scheduler. It runs a default instance (S-mode present,
// hold-off of 2) and a second instance built without S-mode. Both instances
// share the same inputs. The expected {to_s, cause} of each request goes into
// exp_q when the stimulus is applied. It is popped and compared when the DUT
// raises interrupt_pending.
// ---------------------------------------------------------------------------
module tb_interrupt_scheduler;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_HOLDOFF  = 2'd1;
    localparam logic [1:0] S_PRESENT  = 2'd2;
    localparam logic [1:0] S_COOLDOWN = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [11:0] mip, mie, mideleg;
    logic [1:0]  privilege;
    logic        mstatus_mie, mstatus_sie, interrupt_taken, wfi_active;

    logic        pend_a, to_s_a, wake_a;
    logic [3:0]  cause_a, cnt_a;
    logic [1:0]  state_a;
    logic        pend_b, to_s_b, wake_b;
    logic [3:0]  cause_b, cnt_b;
    logic [1:0]  state_b;

    interrupt_scheduler #(.INCLUDE_S_MODE(1), .HOLDOFF_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .mip(mip), .mie(mie), .mideleg(mideleg),
        .privilege(privilege), .mstatus_mie(mstatus_mie), .mstatus_sie(mstatus_sie),
        .interrupt_taken(interrupt_taken), .wfi_active(wfi_active),
        .interrupt_pending(pend_a), .interrupt_cause(cause_a), .interrupt_to_s(to_s_a),
        .wfi_wake(wake_a), .state_dbg(state_a), .holdoff_cnt_dbg(cnt_a)
    );

    interrupt_scheduler #(.INCLUDE_S_MODE(0), .HOLDOFF_CYCLES(2)) dut_nos (
        .clk(clk), .rst(rst), .mip(mip), .mie(mie), .mideleg(mideleg),
        .privilege(privilege), .mstatus_mie(mstatus_mie), .mstatus_sie(mstatus_sie),
        .interrupt_taken(interrupt_taken), .wfi_active(wfi_active),
        .interrupt_pending(pend_b), .interrupt_cause(cause_b), .interrupt_to_s(to_s_b),
        .wfi_wake(wake_b), .state_dbg(state_b), .holdoff_cnt_dbg(cnt_b)
    );

    // ---------------- scoreboard ----------------
    logic [4:0] exp_q[$];   // {to_s, cause}
    logic [4:0] exp_v;
    int errors = 0;
    int checks = 0;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mip = '0; mie = '0; mideleg = '0; privilege = 2'd3;
        mstatus_mie = 1'b0; mstatus_sie = 1'b0;
        interrupt_taken = 1'b0; wfi_active = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        exp_q.delete();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Priority order used to predict the cause: MEI, MSI, MTI, SEI, SSI, STI.
    function automatic logic [3:0] predict_cause(input logic [11:0] q);
        int order[6] = '{11, 3, 7, 9, 1, 5};
        for (int k = 0; k < 6; k++) begin
            if (q[order[k]]) return 4'(order[k]);
        end
        return 4'd0;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({pend_a, cause_a, to_s_a, wake_a, state_a, cnt_a} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got pend=%0b cause=%0d to_s=%0b wake=%0b state=%0d cnt=%0d, want all 0",
                     pend_a, cause_a, to_s_a, wake_a, state_a, cnt_a);
        end
    endtask

    task automatic test_latency();
        do_reset();
        privilege = 2'd3; mstatus_mie = 1'b1; mie[7] = 1'b1;
        mip[7] = 1'b1;                       // cycle 0
        exp_q.push_back({1'b0, 4'd7});
        for (int c = 1; c <= 5; c++) begin
            tick();
            checks++;
            if (pend_a !== (c >= 3)) begin
                errors++;
                $display("FAIL latency_pend_c%0d: got %0b want %0b", c, pend_a, (c >= 3));
            end
            if (c == 3) begin
                exp_v = exp_q.pop_front();
                checks++;
                if ({to_s_a, cause_a} !== exp_v) begin
                    errors++;
                    $display("FAIL latency_cause: got to_s=%0b cause=%0d want %0b/%0d",
                             to_s_a, cause_a, exp_v[4], exp_v[3:0]);
                end
            end
        end
        interrupt_taken = 1'b1;              // taken during cycle 5
        tick();                              // cycle 6
        interrupt_taken = 1'b0;
        checks++;
        if (pend_a !== 1'b0 || state_a !== S_COOLDOWN) begin
            errors++;
            $display("FAIL taken_cooldown: got pend=%0b state=%0d want 0/%0d", pend_a, state_a, S_COOLDOWN);
        end
        tick();                              // cycle 7
        checks++;
        if (state_a !== S_IDLE) begin
            errors++;
            $display("FAIL cooldown_idle: got state=%0d want %0d", state_a, S_IDLE);
        end
        exp_q.push_back({1'b0, 4'd7});
        for (int c = 8; c <= 10; c++) begin
            tick();
            checks++;
            if (pend_a !== (c == 10)) begin
                errors++;
                $display("FAIL reassert_pend_c%0d: got %0b want %0b", c, pend_a, (c == 10));
            end
        end
        exp_v = exp_q.pop_front();
        checks++;
        if ({to_s_a, cause_a} !== exp_v) begin
            errors++;
            $display("FAIL reassert_cause: got %0b/%0d want %0b/%0d", to_s_a, cause_a, exp_v[4], exp_v[3:0]);
        end
    endtask

    task automatic test_priority();
        int n;
        do_reset();
        privilege = 2'd3; mstatus_mie = 1'b1;
        mie[5] = 1'b1; mie[11] = 1'b1; mie[3] = 1'b1;
        mip[5] = 1'b1; mip[11] = 1'b1;
        exp_q.push_back({1'b0, 4'd11});
        n = 0;
        while (!pend_a && n < 20) begin tick(); n++; end
        checks++;
        if (!pend_a) begin
            errors++;
            $display("FAIL prio_timeout: got pend=0 want 1 within 20 cycles");
        end
        exp_v = exp_q.pop_front();
        checks++;
        if ({to_s_a, cause_a} !== exp_v) begin
            errors++;
            $display("FAIL prio_cause: got %0b/%0d want %0b/%0d", to_s_a, cause_a, exp_v[4], exp_v[3:0]);
        end
        mip[3] = 1'b1;                       // arrives while PRESENT
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (pend_a !== 1'b1 || cause_a !== 4'd11) begin
                errors++;
                $display("FAIL prio_hold_%0d: got pend=%0b cause=%0d want 1/11", k, pend_a, cause_a);
            end
        end
        interrupt_taken = 1'b1;
        tick();
        interrupt_taken = 1'b0;
        mip[11] = 1'b0;                      // trap handler cleared MEI
        // On re-entry MSI (3) has priority over STI (5).
        exp_q.push_back({1'b0, 4'd3});
        n = 0;
        while (!pend_a && n < 20) begin tick(); n++; end
        exp_v = exp_q.pop_front();
        checks++;
        if (!pend_a || {to_s_a, cause_a} !== exp_v) begin
            errors++;
            $display("FAIL prio_reentry: got pend=%0b %0b/%0d want 1 %0b/%0d",
                     pend_a, to_s_a, cause_a, exp_v[4], exp_v[3:0]);
        end
    endtask

    task automatic test_pulse();
        do_reset();
        privilege = 2'd3; mstatus_mie = 1'b1; mie[7] = 1'b1;
        mip[7] = 1'b1;
        tick();
        tick();
        checks++;
        if (state_a !== S_HOLDOFF || cnt_a !== 4'd1) begin
            errors++;
            $display("FAIL pulse_holdoff: got state=%0d cnt=%0d want %0d/1", state_a, cnt_a, S_HOLDOFF);
        end
        mip[7] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (pend_a !== 1'b0) begin
                errors++;
                $display("FAIL pulse_pend_%0d: got %0b want 0", k, pend_a);
            end
        end
        checks++;
        if (state_a !== S_IDLE || cnt_a !== 4'd0) begin
            errors++;
            $display("FAIL pulse_idle: got state=%0d cnt=%0d want 0/0", state_a, cnt_a);
        end
    endtask

    task automatic test_deleg();
        int n;
        logic b_seen;
        do_reset();
        b_seen = 1'b0;
        mideleg[9] = 1'b1; mip[9] = 1'b1; mie[9] = 1'b1;
        privilege = 2'd3; mstatus_mie = 1'b1; mstatus_sie = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            b_seen = b_seen | pend_b;
            checks++;
            if (pend_a !== 1'b0) begin
                errors++;
                $display("FAIL deleg_mmode_%0d: got pend=%0b want 0", k, pend_a);
            end
        end
        privilege = 2'd1;
        exp_q.push_back({1'b1, 4'd9});
        n = 0;
        while (!pend_a && n < 20) begin tick(); b_seen = b_seen | pend_b; n++; end
        exp_v = exp_q.pop_front();
        checks++;
        if (!pend_a || {to_s_a, cause_a} !== exp_v) begin
            errors++;
            $display("FAIL deleg_smode: got pend=%0b %0b/%0d want 1 %0b/%0d",
                     pend_a, to_s_a, cause_a, exp_v[4], exp_v[3:0]);
        end
        mstatus_sie = 1'b0;                  // withdraw without taken
        tick();
        b_seen = b_seen | pend_b;
        checks++;
        if (pend_a !== 1'b0 || state_a !== S_IDLE) begin
            errors++;
            $display("FAIL deleg_withdraw: got pend=%0b state=%0d want 0/0", pend_a, state_a);
        end
        checks++;
        if (b_seen !== 1'b0) begin
            errors++;
            $display("FAIL nos_pending: got pend seen=%0b want 0", b_seen);
        end
    endtask

    task automatic test_wfi();
        do_reset();
        mstatus_mie = 1'b0; privilege = 2'd3;
        mip[11] = 1'b1; mie[11] = 1'b1; wfi_active = 1'b1;
        tick();
        checks++;
        if (wake_a !== 1'b1) begin
            errors++;
            $display("FAIL wfi_wake: got %0b want 1", wake_a);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (pend_a !== 1'b0) begin
                errors++;
                $display("FAIL wfi_no_pend_%0d: got %0b want 0", k, pend_a);
            end
        end
        mie[11] = 1'b0;
        tick();
        checks++;
        if (wake_a !== 1'b0) begin
            errors++;
            $display("FAIL wfi_disabled: got %0b want 0", wake_a);
        end
    endtask

    task automatic test_taken_reset();
        int n;
        do_reset();
        privilege = 2'd3; mstatus_mie = 1'b1; mie[7] = 1'b1; mip[7] = 1'b1;
        wfi_active = 1'b1;
        n = 0;
        while (!pend_a && n < 20) begin tick(); n++; end
        checks++;
        if (!pend_a) begin
            errors++;
            $display("FAIL tr_timeout: got pend=0 want 1 within 20 cycles");
        end
        interrupt_taken = 1'b1; rst = 1'b1;
        tick();
        interrupt_taken = 1'b0; rst = 1'b0;
        checks++;
        if ({pend_a, cause_a, to_s_a, wake_a, state_a} !== 9'd0) begin
            errors++;
            $display("FAIL taken_vs_reset: got pend=%0b cause=%0d to_s=%0b wake=%0b state=%0d want all 0",
                     pend_a, cause_a, to_s_a, wake_a, state_a);
        end
    endtask

    task automatic test_taken_withdraw();
        int n;
        do_reset();
        privilege = 2'd3; mstatus_mie = 1'b1; mie[7] = 1'b1; mip[7] = 1'b1;
        n = 0;
        while (!pend_a && n < 20) begin tick(); n++; end
        interrupt_taken = 1'b1; mip[7] = 1'b0;
        tick();
        interrupt_taken = 1'b0;
        checks++;
        if (state_a !== S_COOLDOWN || pend_a !== 1'b0) begin
            errors++;
            $display("FAIL taken_beats_withdraw: got state=%0d pend=%0b want %0d/0", state_a, pend_a, S_COOLDOWN);
        end
        tick();
        checks++;
        if (state_a !== S_IDLE) begin
            errors++;
            $display("FAIL tw_idle: got state=%0d want 0", state_a);
        end
    endtask

    task automatic test_random();
        int n;
        int r;
        logic [11:0] sel;
        int map[6] = '{1, 3, 5, 7, 9, 11};
        int privs[3] = '{0, 1, 3};
        do_reset();
        mstatus_mie = 1'b1; mie = 12'hFFF;
        for (int it = 0; it < 10; it++) begin
            r = $urandom_range(1, 63);
            sel = '0;
            for (int k = 0; k < 6; k++) if (r[k]) sel[map[k]] = 1'b1;
            privilege = 2'(privs[$urandom_range(0, 2)]);
            mip = sel;
            exp_q.push_back({1'b0, predict_cause(sel)});
            n = 0;
            while (!pend_a && n < 20) begin tick(); n++; end
            exp_v = exp_q.pop_front();
            checks++;
            if (!pend_a || {to_s_a, cause_a} !== exp_v) begin
                errors++;
                $display("FAIL rand_%0d: mip=%03h got pend=%0b %0b/%0d want 1 %0b/%0d",
                         it, sel, pend_a, to_s_a, cause_a, exp_v[4], exp_v[3:0]);
            end
            interrupt_taken = 1'b1; mip = '0;
            tick();
            interrupt_taken = 1'b0;
            tick();
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_latency();
        test_priority();
        test_pulse();
        test_deleg();
        test_wfi();
        test_taken_reset();
        test_taken_withdraw();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
